// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one external magnitude comparator between NREQ requesters.
// Each accepted operand pair produces exactly one id-tagged gt/ls/eq response.
module cmp_share_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      cmp_a,
  output logic [N-1:0]      cmp_b,
  input  logic              cmp_gt,
  input  logic              cmp_ls,
  input  logic              cmp_eq,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_gt,
  output logic              rsp_ls,
  output logic              rsp_eq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_next_ptr;
  logic             w_found;
  logic             w_accept;
  logic [NREQ-1:0]  w_grant;
  logic [N-1:0]     w_sel_a;
  logic [N-1:0]     w_sel_b;
  logic [N-1:0]     r_cmp_a;
  logic [N-1:0]     r_cmp_b;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_valid;
  logic             r_rsp_gt;
  logic             r_rsp_ls;
  logic             r_rsp_eq;

  // Round-robin search: first valid requester starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Grant decode, winner operand mux and pointer advance.
  always_comb begin
    w_accept = 1'b0;
    w_grant  = '0;
    if (rst_n && (r_state == ST_IDLE) && w_found) begin
      w_accept = 1'b1;
      w_grant  = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    end else begin
      w_accept = 1'b0;
      w_grant  = '0;
    end
    w_sel_a = req_a[int'(w_winner)*N +: N];
    w_sel_b = req_b[int'(w_winner)*N +: N];
    if (int'(w_winner) == (NREQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_winner + IDW'(1);
    end
  end

  // Next-state logic for the accept / compare / respond sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_CMP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CMP: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture, requester id and fairness pointer update on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_a  <= '0;
      r_cmp_b  <= '0;
      r_rsp_id <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_cmp_a  <= w_sel_a;
      r_cmp_b  <= w_sel_b;
      r_rsp_id <= w_winner;
      r_rr_ptr <= w_next_ptr;
    end
  end

  // Result capture; flags are taken raw so a faulty comparator stays visible downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_gt    <= 1'b0;
      r_rsp_ls    <= 1'b0;
      r_rsp_eq    <= 1'b0;
    end else begin
      case (r_state)
        ST_CMP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_gt    <= cmp_gt;
          r_rsp_ls    <= cmp_ls;
          r_rsp_eq    <= cmp_eq;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_grant;
  assign cmp_a     = r_cmp_a;
  assign cmp_b     = r_cmp_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_gt    = r_rsp_gt;
  assign rsp_ls    = r_rsp_ls;
  assign rsp_eq    = r_rsp_eq;

endmodule
